// File: rtl/seq_mul_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_mul_unit                                                   |
// | Brief   : Multi-cycle shift-and-add multiplier for MUL/MULH/MULHSU/MULHU |
// |           with start/busy/done handshake and kill abort.                 |
// |           Optional macro SEQ_MUL_EARLY_TERM_EN ends iteration as soon as |
// |           the remaining multiplier is zero.                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seq_mul_unit #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam logic [N-1:0]     c_one_n   = N'(1);
  localparam logic [2*N-1:0]   c_one_2n  = (2*N)'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_end = CNT_W'(N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic             r_neg;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplr;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_result;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [N-1:0]     w_a_abs;
  logic [N-1:0]     w_b_abs;
  logic [N-1:0]     w_mplr_shift;
  logic [2*N-1:0]   w_addend;
  logic [2*N-1:0]   w_sum;
  logic [2*N-1:0]   w_carry;
  logic [2*N-1:0]   w_fix_acc;
  logic [N-1:0]     w_sel;

  // a is signed for MULH/MULHSU, b only for MULH; MUL low half is sign-independent.
  assign w_accept     = (r_state == S_IDLE) && start && !kill;
  assign w_a_neg      = ((op == 2'b01) || (op == 2'b10)) && a[N-1];
  assign w_b_neg      = (op == 2'b01) && b[N-1];
  assign w_a_abs      = w_a_neg ? (~a + c_one_n) : a;
  assign w_b_abs      = w_b_neg ? (~b + c_one_n) : b;
  assign w_mplr_shift = r_mplr >> 1;
  assign w_addend     = r_mplr[0] ? r_mcand : '0;

  assign w_carry[0] = 1'b0;
  for (genvar i = 0; i < 2*N; i++) begin : g_rca
    assign w_sum[i] = r_acc[i] ^ w_addend[i] ^ w_carry[i];
    if (i < 2*N-1) begin : g_carry
      assign w_carry[i+1] = (r_acc[i] & w_addend[i]) |
                            (w_carry[i] & (r_acc[i] ^ w_addend[i]));
    end
  end

  assign w_fix_acc = r_neg ? (~r_acc + c_one_2n) : r_acc;
  assign w_sel     = (r_op == 2'b00) ? w_fix_acc[N-1:0] : w_fix_acc[2*N-1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
          w_state_nxt = (w_b_abs == '0) ? S_FIX : S_RUN;
`else
          w_state_nxt = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (kill) begin
          w_state_nxt = S_IDLE;
`ifdef SEQ_MUL_EARLY_TERM_EN
        end else if ((r_cnt == c_cnt_end) || (w_mplr_shift == '0)) begin
`else
        end else if (r_cnt == c_cnt_end) begin
`endif
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A killed operation never touches result, so the previous product stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_acc   <= '0;
            r_mcand <= {{N{1'b0}}, w_a_abs};
            r_mplr  <= w_b_abs;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (!kill) begin
            if (r_mplr[0]) begin
              r_acc <= w_sum;
            end
            r_mcand <= r_mcand << 1;
            r_mplr  <= w_mplr_shift;
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        S_FIX: begin
          if (!kill) begin
            r_acc    <= w_fix_acc;
            r_result <= w_sel;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seq_mul_unit                                                |
// | Brief   : Directed self-checking bench for seq_mul_unit.                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seq_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_unit #(.N(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycle of the done pulse for a given multiplier magnitude.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [31:0] mag;
    int k;
    mag = (o == 2'b01 && y[31]) ? (~y + 32'd1) : y;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
    return (k == 0) ? 2 : k + 2;
`else
    return 34;
`endif
  endfunction

  // Presents a request for edge 0; returns sampling in cycle 1.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res);
    launch(o, x, y);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (lat >= 100) lat = 999;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul_basic;
    int el;
    int seen;
    el = exp_lat(2'b00, 32'd5);
    seen = 0;
    launch(2'b00, 32'd3, 32'd5);
    for (int cyc = 1; cyc <= el + 1; cyc++) begin
      n_checks++;
      if (busy !== (cyc <= el)) begin
        n_fail++;
        $display("FAIL basic_busy cycle %0d: busy=%b, required %b", cyc, busy, (cyc <= el));
      end
      n_checks++;
      if (done !== (cyc == el)) begin
        n_fail++;
        $display("FAIL basic_done cycle %0d: done=%b, required %b", cyc, done, (cyc == el));
      end
      if (done === 1'b1) begin
        seen++;
        n_checks++;
        if (result !== 32'd15) begin
          n_fail++;
          $display("FAIL basic_result: result=%h, required 0000000f", result);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL basic_done_count: pulses=%0d, required 1", seen);
    end
  endtask

  task automatic test_products;
    logic [1:0]  v_op  [12];
    logic [31:0] v_a   [12];
    logic [31:0] v_b   [12];
    logic [31:0] v_exp [12];
    int lat;
    logic [31:0] res;
    v_op[0]  = 2'b00; v_a[0]  = 32'd3;        v_b[0]  = 32'd5;        v_exp[0]  = 32'h0000000F;
    v_op[1]  = 2'b01; v_a[1]  = 32'hFFFFFFFF; v_b[1]  = 32'hFFFFFFFF; v_exp[1]  = 32'h00000000;
    v_op[2]  = 2'b11; v_a[2]  = 32'hFFFFFFFF; v_b[2]  = 32'hFFFFFFFF; v_exp[2]  = 32'hFFFFFFFE;
    v_op[3]  = 2'b00; v_a[3]  = 32'hFFFFFFFF; v_b[3]  = 32'hFFFFFFFF; v_exp[3]  = 32'h00000001;
    v_op[4]  = 2'b10; v_a[4]  = 32'hFFFFFFFF; v_b[4]  = 32'd2;        v_exp[4]  = 32'hFFFFFFFF;
    v_op[5]  = 2'b01; v_a[5]  = 32'h80000000; v_b[5]  = 32'h80000000; v_exp[5]  = 32'h40000000;
    v_op[6]  = 2'b01; v_a[6]  = 32'hFFFFFFFD; v_b[6]  = 32'd7;        v_exp[6]  = 32'hFFFFFFFF;
    v_op[7]  = 2'b00; v_a[7]  = 32'hFFFFFFFD; v_b[7]  = 32'd7;        v_exp[7]  = 32'hFFFFFFEB;
    v_op[8]  = 2'b10; v_a[8]  = 32'd2;        v_b[8]  = 32'hFFFFFFFF; v_exp[8]  = 32'h00000001;
    v_op[9]  = 2'b01; v_a[9]  = 32'h7FFFFFFF; v_b[9]  = 32'h7FFFFFFF; v_exp[9]  = 32'h3FFFFFFF;
    v_op[10] = 2'b11; v_a[10] = 32'h80000000; v_b[10] = 32'd2;        v_exp[10] = 32'h00000001;
    v_op[11] = 2'b01; v_a[11] = 32'h80000000; v_b[11] = 32'd1;        v_exp[11] = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat, res);
      n_checks++;
      if (res !== v_exp[i]) begin
        n_fail++;
        $display("FAIL product_%0d op=%b a=%h b=%h: result=%h, required %h", i, v_op[i], v_a[i], v_b[i], res, v_exp[i]);
      end
      n_checks++;
      if (lat != exp_lat(v_op[i], v_b[i])) begin
        n_fail++;
        $display("FAIL latency_%0d: done at cycle %0d, required %0d", i, lat, exp_lat(v_op[i], v_b[i]));
      end
    end
  endtask

  // Starts at cycles 5/20 and in the done cycle must all be dropped.
  task automatic test_start_ignored;
    launch(2'b00, 32'd3, 32'h80000005);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      n_checks++;
      if (busy !== (cyc <= 34) || done !== (cyc == 34)) begin
        n_fail++;
        $display("FAIL ignore_hs cycle %0d: busy=%b done=%b, required %b %b", cyc, busy, done, (cyc <= 34), (cyc == 34));
      end
      if (cyc == 34) begin
        n_checks++;
        if (result !== 32'h8000000F) begin
          n_fail++;
          $display("FAIL ignore_result: result=%h, required 8000000f", result);
        end
      end
      @(negedge clk);
      start = (cyc == 5 || cyc == 20 || cyc == 34);
      op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_kill;
    int kc [2];
    kc[0] = 10; kc[1] = 33;
    for (int t = 0; t < 2; t++) begin
      launch(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int cyc = 1; cyc <= 40; cyc++) begin
        n_checks++;
        if (busy !== (cyc <= kc[t]) || done !== 1'b0 || result !== 32'h8000000F) begin
          n_fail++;
          $display("FAIL kill_at_%0d cycle %0d: busy=%b done=%b result=%h, required %b 0 8000000f",
                   kc[t], cyc, busy, done, result, (cyc <= kc[t]));
        end
        @(negedge clk);
        kill = (cyc == kc[t]);
        @(posedge clk); #1;
      end
      kill = 1'b0;
    end
    // Kill in the done cycle: the pulse is already committed.
    launch(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int cyc = 1; cyc < 34; cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    kill = 1'b1;
    n_checks++;
    if (done !== 1'b1 || result !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL kill_in_done: done=%b result=%h, required 1 fffffffe", done, result);
    end
    @(posedge clk); #1;
    kill = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_in_done_idle: busy=%b, required 0", busy);
    end
    // start and kill together in IDLE: request dropped.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_in_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [31:0] res;
    launch(2'b00, 32'd3, 32'h80000005);
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    n_checks++;
    if (res !== 32'hFFFFFFFE || lat != 34) begin
      n_fail++;
      $display("FAIL after_reset_op: result=%h lat=%0d, required fffffffe 34", res, lat);
    end
  endtask

  task automatic test_early_term;
    int lat;
    logic [31:0] res;
    run_op(2'b11, 32'hFFFFFFFF, 32'd1, lat, res);
    n_checks++;
    if (res !== 32'h0 || lat != exp_lat(2'b11, 32'd1)) begin
      n_fail++;
      $display("FAIL early_b1: result=%h lat=%0d, required 00000000 %0d", res, lat, exp_lat(2'b11, 32'd1));
    end
    run_op(2'b11, 32'hFFFFFFFF, 32'd0, lat, res);
    n_checks++;
    if (res !== 32'h0 || lat != exp_lat(2'b11, 32'd0)) begin
      n_fail++;
      $display("FAIL early_b0: result=%h lat=%0d, required 00000000 %0d", res, lat, exp_lat(2'b11, 32'd0));
    end
    run_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFF9, lat, res);
    n_checks++;
    if (res !== 32'h0 || lat != exp_lat(2'b01, 32'hFFFFFFF9)) begin
      n_fail++;
      $display("FAIL early_neg: result=%h lat=%0d, required 00000000 %0d", res, lat, exp_lat(2'b01, 32'hFFFFFFF9));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_products();
    test_start_ignored();
    test_kill();
    test_reset_mid_run();
    test_early_term();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
